// File: rtl/fp_widen_pkg.sv
// rtl/fp_widen_pkg.sv - shared float format helpers for the fp_widen slice
//
// Purpose: exponent bias / max helpers, the packed {sign, exp, mant} field
// layout, the operand class encoding and the NaN counter width, shared by
// fp_widen and fp_widen_clz.
// Ports: none (package).
package fp_widen_pkg;

  // NaN counter width and its saturation value.
  localparam int                   NAN_CNT_W   = 16;
  localparam logic [NAN_CNT_W-1:0] NAN_CNT_MAX = {NAN_CNT_W{1'b1}};

  // Operand classes decided in stage 1 and consumed in stage 2.
  typedef enum logic [2:0] {
    CLS_ZERO = 3'd0,
    CLS_NORM = 3'd1,
    CLS_SUB  = 3'd2,
    CLS_INF  = 3'd3,
    CLS_NAN  = 3'd4
  } fp_class_e;

  // IEEE-style exponent bias for an nx-bit exponent field.
  function automatic int exp_offset(input int nx);
    return (1 << (nx - 1)) - 1;
  endfunction

  // All-ones exponent (Inf/NaN encoding) for an nx-bit exponent field.
  function automatic int exp_max(input int nx);
    return (1 << nx) - 1;
  endfunction

  // Packed layout: {sign, exp[nx-1:0], mant[nm-1:0]}, mantissa at bit 0.
  function automatic int fp_width(input int nx, input int nm);
    return nx + nm + 1;
  endfunction

  function automatic int sign_pos(input int nx, input int nm);
    return nx + nm;
  endfunction

  function automatic int exp_lsb(input int nm);
    return nm;
  endfunction

endpackage

// File: rtl/fp_widen_clz.sv
// rtl/fp_widen_clz.sv - combinational leading-zero counter over N bits
//
// Purpose: counts leading zeros of data_i, used to normalise subnormal
// mantissas in stage 1 of fp_widen.
// Ports:
//   data_i  in  N       value to scan, MSB first
//   cnt_o   out clog2(N) number of zeros above the highest set bit
// An all-zero input returns N-1; callers only use the count for non-zero
// mantissas.
module fp_widen_clz #(
  parameter  int N = 10,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] data_i,
  output logic [W-1:0] cnt_o
);

  // Scan upward so the highest set bit is the last assignment and wins.
  always_comb begin
    cnt_o = W'(N - 1);
    for (int i = 0; i < N; i++) begin
      if (data_i[i]) begin
        cnt_o = W'(N - 1 - i);
      end
    end
  end

endmodule

// File: rtl/fp_widen.sv
// rtl/fp_widen.sv - two-stage pipelined narrow-to-wide float converter
//
// Purpose: widens a packed {sign, exp, mant} float of NX/NM bits to ONX/ONM
// bits. Stage 1 classifies the operand (and counts leading zeros of
// subnormal mantissas); stage 2 shifts, rebiases and assembles the result.
// Latency is 2 cycles; both stages stall together on output backpressure.
// Build option: define FP_WIDEN_SUBNORM_EN to normalise subnormal inputs
// (instantiates fp_widen_clz); otherwise subnormals flush to signed zero.
// Ports:
//   CLK        in   1          clock, rising edge
//   RST        in   1          synchronous active-high reset
//   IN_VALID   in   1          IN_DATA valid
//   IN_READY   out  1          input accepted this cycle when IN_VALID=1
//   IN_DATA    in   NX+NM+1    narrow float {sign, exp, mant}
//   OUT_VALID  out  1          OUT_DATA valid
//   OUT_READY  in   1          consumer accepts OUT_DATA
//   OUT_DATA   out  ONX+ONM+1  wide float {sign, exp, mant}
//   NAN_CNT    out  16         saturating count of accepted NaN inputs
module fp_widen
  import fp_widen_pkg::*;
#(
  parameter int NX  = 5,
  parameter int NM  = 10,
  parameter int ONX = 8,
  parameter int ONM = 23
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [NX+NM:0]       IN_DATA,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [ONX+ONM:0]     OUT_DATA,
  output logic [NAN_CNT_W-1:0] NAN_CNT
);

  localparam int OW = fp_width(ONX, ONM);
  localparam logic [NX-1:0]  IN_EXP_MAX  = NX'(exp_max(NX));
  localparam logic [ONX-1:0] OUT_EXP_MAX = ONX'(exp_max(ONX));
  // Rebias amount added to a narrow exponent to get the wide exponent.
  localparam logic [ONX-1:0] BIAS_DIFF   = ONX'(exp_offset(ONX) - exp_offset(NX));
  localparam logic [ONM-NM-1:0] MANT_PAD = '0;

  // ---------------------------------------------------------------- input
  logic          in_sign;
  logic [NX-1:0] in_exp;
  logic [NM-1:0] in_mant;
  logic          in_fire;
  logic          advance;

  assign in_sign = IN_DATA[sign_pos(NX, NM)];
  assign in_exp  = IN_DATA[exp_lsb(NM) +: NX];
  assign in_mant = IN_DATA[NM-1:0];

  // One shared enable for both stages: the pipe moves only when the output
  // register is free or being drained this cycle.
  assign IN_READY = !RST && (!OUT_VALID || OUT_READY);
  assign advance  = IN_READY;
  assign in_fire  = IN_VALID && IN_READY;

  // -------------------------------------------------------- stage 1 logic
  fp_class_e s1_cls_d;

  always_comb begin
    s1_cls_d = CLS_NORM;
    if (in_exp == '0) begin
      if (in_mant == '0) begin
        s1_cls_d = CLS_ZERO;
      end else begin
`ifdef FP_WIDEN_SUBNORM_EN
        s1_cls_d = CLS_SUB;
`else
        s1_cls_d = CLS_ZERO;
`endif
      end
    end else if (in_exp == IN_EXP_MAX) begin
      s1_cls_d = (in_mant == '0) ? CLS_INF : CLS_NAN;
    end
  end

`ifdef FP_WIDEN_SUBNORM_EN
  localparam int LZW = (NM > 1) ? $clog2(NM) : 1;
  logic [LZW-1:0] s1_lz_d;
  logic [LZW-1:0] s1_lz_q;

  fp_widen_clz #(
    .N (NM)
  ) u_clz (
    .data_i (in_mant),
    .cnt_o  (s1_lz_d)
  );
`endif

  // ------------------------------------------------------ stage 1 registers
  logic          s1_valid_q;
  logic          s1_sign_q;
  fp_class_e     s1_cls_q;
  logic [NX-1:0] s1_exp_q;
  logic [NM-1:0] s1_mant_q;

  // Payload needs no reset: it is only consumed while s1_valid_q is set.
  always_ff @(posedge CLK) begin
    if (in_fire) begin
      s1_sign_q <= in_sign;
      s1_cls_q  <= s1_cls_d;
      s1_exp_q  <= in_exp;
      s1_mant_q <= in_mant;
`ifdef FP_WIDEN_SUBNORM_EN
      s1_lz_q   <= s1_lz_d;
`endif
    end
  end

  // -------------------------------------------------------- stage 2 logic
  logic [ONX-1:0] out_exp;
  logic [ONM-1:0] out_mant;
  logic [OW-1:0]  out_data_d;

`ifdef FP_WIDEN_SUBNORM_EN
  // Shift out the leading zeros plus the implicit one; split in two steps
  // so lz+1 never needs an extra bit of shift amount.
  logic [NM-1:0] sub_mant;
  assign sub_mant = (s1_mant_q << s1_lz_q) << 1;
`endif

  always_comb begin
    out_exp  = '0;
    out_mant = '0;
    case (s1_cls_q)
      CLS_NORM: begin
        out_exp  = {{(ONX-NX){1'b0}}, s1_exp_q} + BIAS_DIFF;
        out_mant = {s1_mant_q, MANT_PAD};
      end
      CLS_INF: begin
        out_exp  = OUT_EXP_MAX;
      end
      CLS_NAN: begin
        // Payload kept, top mantissa bit forced so the result is quiet.
        out_exp            = OUT_EXP_MAX;
        out_mant           = {s1_mant_q, MANT_PAD};
        out_mant[ONM-1]    = 1'b1;
      end
`ifdef FP_WIDEN_SUBNORM_EN
      CLS_SUB: begin
        out_exp  = BIAS_DIFF - ONX'(s1_lz_q);
        out_mant = {sub_mant, MANT_PAD};
      end
`endif
      default: begin
        out_exp  = '0;
        out_mant = '0;
      end
    endcase
  end

  assign out_data_d = {s1_sign_q, out_exp, out_mant};

  // ----------------------------------------------- control and output regs
  logic                 out_valid_q;
  logic [OW-1:0]        out_data_q;
  logic [NAN_CNT_W-1:0] nan_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      nan_cnt_q   <= '0;
    end else begin
      if (advance) begin
        s1_valid_q  <= IN_VALID;
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_data_q <= out_data_d;
        end
      end
      if (in_fire && (s1_cls_d == CLS_NAN) && (nan_cnt_q != NAN_CNT_MAX)) begin
        nan_cnt_q <= nan_cnt_q + 1'b1;
      end
    end
  end

  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_data_q;
  assign NAN_CNT   = nan_cnt_q;

endmodule

// File: doc/fp_widen.md
FP_WIDEN -- requirements
Module: fp_widen

Interface
REQ-001 SHALL have parameter NX, default 5, input exponent width.
REQ-002 SHALL have parameter NM, default 10, input mantissa width.
REQ-003 SHALL have parameter ONX, default 8, output exponent width; ONX > NX.
REQ-004 SHALL have parameter ONM, default 23, output mantissa width; ONM > NM.
REQ-005 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port IN_VALID  input  1  IN_DATA valid.
REQ-008 SHALL have port IN_READY  output  1  block accepts IN_DATA this cycle.
REQ-009 SHALL have port IN_DATA  input  NX+NM+1  packed {sign, exp, mant} narrow float.
REQ-010 SHALL have port OUT_VALID  output  1  OUT_DATA valid.
REQ-011 SHALL have port OUT_READY  input  1  consumer accepts OUT_DATA.
REQ-012 SHALL have port OUT_DATA  output  ONX+ONM+1  packed widened float.
REQ-013 SHALL have port NAN_CNT  output  16  saturating count of accepted NaN inputs.

Function
REQ-014 SHALL be a 2-stage pipeline: stage 1 classify and leading-zero count; stage 2 shift, exponent rebias and assemble; latency exactly 2 cycles from input handshake to OUT_VALID without backpressure.
REQ-015 SHALL sustain one transfer per cycle while OUT_READY=1.
REQ-016 SHALL transfer on IN_VALID&IN_READY (input) and OUT_VALID&OUT_READY (output).
REQ-017 SHALL drive IN_READY = !OUT_VALID | OUT_READY; when low, both stages hold contents.
REQ-018 SHALL hold OUT_DATA stable while OUT_VALID=1 and OUT_READY=0.
REQ-019 Normal input: sign copied; exp_out = exp_in - EXP_OFFSET(NX) + EXP_OFFSET(ONX); mant_out = {mant_in, (ONM-NM) zeros}.
REQ-020 Zero (exp=0, mant=0): output signed zero, sign preserved.
REQ-021 Infinity (exp all ones, mant=0): output exp all ones, mant 0, sign preserved.
REQ-022 NaN (exp all ones, mant!=0): output exp all ones, mant = {mant_in, zeros} with MSB forced to 1 (quiet), sign preserved.
REQ-023 Subnormal (exp=0, mant!=0), lz = leading zeros of mant_in (0..NM-1): mant_in shifted left by lz+1, truncated to NM bits, zero-extended to ONM; exp_out = EXP_OFFSET(ONX) - EXP_OFFSET(NX) - lz.
REQ-024 NAN_CNT SHALL increment by 1 per accepted NaN input and saturate at 0xFFFF.
REQ-025 Stage 2 may hold a transfer while stage 1 is empty; bubbles need not be squeezed.

Reset
REQ-026 RST SHALL clear both stage valid bits, OUT_VALID=0, OUT_DATA=0, NAN_CNT=0 at the next CLK edge, including mid-operation; in-flight data SHALL be discarded.
REQ-027 While RST=1, IN_READY SHALL be 0 and no input SHALL be accepted.

Configuration
REQ-028 Macro FP_WIDEN_SUBNORM_EN SHALL select subnormal handling.
REQ-029 With FP_WIDEN_SUBNORM_EN defined: subnormals SHALL be normalized per REQ-023 and the CLZ sub-module instantiated.
REQ-030 Without it: subnormal inputs SHALL flush to signed zero and no CLZ logic SHALL be instantiated; latency and handshake unchanged.

Structure
REQ-031 EXP_OFFSET, MAX, the packed {sign, exp, mant} layout and NAN_CNT width SHALL live in the shared fp package.
REQ-032 Leading-zero count over NM bits SHALL be sub-module fp_widen_clz (parameter N, output width clog2(N)), purely combinational, instanced in stage 1.
REQ-033 All other logic SHALL be in fp_widen.

Verification (defaults NX=5, NM=10, ONX=8, ONM=23)
REQ-034 Stream 0x3C00, 0xC000, 0x0000, 0x8000 back-to-back, OUT_READY=1 -> 0x3F800000, 0xC0000000, 0x00000000, 0x80000000, each 2 cycles after acceptance, one per cycle.
REQ-035 With FP_WIDEN_SUBNORM_EN: 0x0001 -> 0x33800000; 0x03FF -> 0x387FC000; 0x8200 -> 0xB8000000. Without: 0x0001 -> 0x00000000; 0x8200 -> 0x80000000.
REQ-036 0x7C00 -> 0x7F800000; 0xFC00 -> 0xFF800000; 0x7C01 -> 0x7FC02000 with NAN_CNT 0 -> 1.
REQ-037 Backpressure: drive 5 inputs, hold OUT_READY=0 for 4 cycles -> IN_READY drops, OUT_DATA stable, no loss or duplication; release -> all 5 delivered in order.
REQ-038 Reset mid-stream with 2 transfers in flight and NAN_CNT=3 -> next cycle OUT_VALID=0, NAN_CNT=0, no stale output after reset release; 70000 NaN inputs -> NAN_CNT=0xFFFF.
